manager_tx_arbiter: RTL and testbench

MANAGER_TX_ARBITER -- requirements
Module: manager_tx_arbiter

---
 rtl/manager_tx_arbiter_pkg.sv | 26 ++
 rtl/manager_tx_arbiter_rr_arbiter.sv | 35 +++
 rtl/manager_tx_arbiter.sv | 149 ++++++++++++++
 tb/tb_manager_tx_arbiter.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/manager_tx_arbiter_pkg.sv
// Shared definitions for the RS232 transmit arbiter.
//   - FSM state encoding
//   - byte width, default requester count and busy-wait timeout
//   - idx_width(): index width helper that never returns 0
package manager_tx_arbiter_pkg;

  localparam int BYTE_W      = 8;
  localparam int DEF_N_REQ   = 4;
  localparam int DEF_TIMEOUT = 1023;

  typedef enum logic [2:0] {
    IDLE         = 3'd0,
    SEND_ADDR    = 3'd1,
    WAIT_ADDR_HI = 3'd2,
    WAIT_ADDR_LO = 3'd3,
    SEND_DATA    = 3'd4,
    WAIT_DATA_HI = 3'd5,
    WAIT_DATA_LO = 3'd6,
    DONE         = 3'd7
  } state_t;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/manager_tx_arbiter_rr_arbiter.sv
// Combinational round-robin selector.
//   req       : request vector
//   last      : index granted most recently
//   grant_idx : first requester found scanning last+1, last+2, ... (wrapping)
//   valid     : any request present
module rr_arbiter
  import manager_tx_arbiter_pkg::*;
#(
  parameter int N_REQ = DEF_N_REQ,
  parameter int IDX_W = idx_width(DEF_N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] last,
  output logic [IDX_W-1:0] grant_idx,
  output logic             valid
);

  logic [IDX_W-1:0] idx;

  // Scan from the farthest candidate to the nearest; the last hit wins,
  // so the requester closest after 'last' takes the grant.
  always_comb begin
    grant_idx = '0;
    valid     = 1'b0;
    idx       = '0;
    for (int k = N_REQ; k >= 1; k--) begin
      idx = IDX_W'((int'(last) + k) % N_REQ);
      if (req[idx]) begin
        grant_idx = idx;
        valid     = 1'b1;
      end
    end
  end

endmodule

// File: rtl/manager_tx_arbiter.sv
// Shares one RS232 transmitter among N_REQ requesters. Each granted
// requester gets a two-byte frame (address byte, then data byte); the
// bytes are latched at grant so later input changes do not matter.
//   CLK_50MHZ, RST        : clock, async active-high reset
//   req/addr_tx/data_tx   : per-requester request level and frame bytes
//   ack                   : one-cycle pulse when the frame finishes/aborts
//   RS_BUSY               : UART busy input
//   RS_DATAIN/RS_TRG_WRITE: byte and write strobe to the UART
//   tx_err                : one-cycle pulse when RS_BUSY never rose
//   busy                  : arbiter is mid-frame
module manager_tx_arbiter
  import manager_tx_arbiter_pkg::*;
#(
  parameter int N_REQ   = DEF_N_REQ,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic                      CLK_50MHZ,
  input  logic                      RST,
  input  logic [N_REQ-1:0]          req,
  input  logic [BYTE_W*N_REQ-1:0]   addr_tx,
  input  logic [BYTE_W*N_REQ-1:0]   data_tx,
  output logic [N_REQ-1:0]          ack,
  input  logic                      RS_BUSY,
  output logic [BYTE_W-1:0]         RS_DATAIN,
  output logic                      RS_TRG_WRITE,
  output logic                      tx_err,
  output logic                      busy
);

  localparam int IDX_W = idx_width(N_REQ);
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  state_t              state_q, state_nxt;
  logic [IDX_W-1:0]    last_q, last_nxt;
  logic [IDX_W-1:0]    gnt_q, gnt_nxt;
  logic [CNT_W-1:0]    cnt_q, cnt_nxt;
  logic [BYTE_W-1:0]   addr_q, addr_nxt;
  logic [BYTE_W-1:0]   data_q, data_nxt;
  logic [BYTE_W-1:0]   datain_nxt;
  logic                trg_nxt, err_nxt;
  logic [N_REQ-1:0]    ack_nxt;

  logic [IDX_W-1:0]    rr_idx;
  logic                rr_vld;

  rr_arbiter #(.N_REQ(N_REQ), .IDX_W(IDX_W)) u_rr (
    .req      (req),
    .last     (last_q),
    .grant_idx(rr_idx),
    .valid    (rr_vld)
  );

  // Outputs are registered from next-state decisions, so a strobe or
  // pulse is visible during exactly the cycle the FSM sits in the
  // corresponding state.
  always_comb begin
    state_nxt  = state_q;
    last_nxt   = last_q;
    gnt_nxt    = gnt_q;
    cnt_nxt    = '0;
    addr_nxt   = addr_q;
    data_nxt   = data_q;
    datain_nxt = RS_DATAIN;
    trg_nxt    = 1'b0;
    err_nxt    = 1'b0;
    ack_nxt    = '0;
    unique case (state_q)
      IDLE: begin
        if (rr_vld && !RS_BUSY) begin
          gnt_nxt    = rr_idx;
          addr_nxt   = addr_tx[rr_idx*BYTE_W +: BYTE_W];
          data_nxt   = data_tx[rr_idx*BYTE_W +: BYTE_W];
          datain_nxt = addr_tx[rr_idx*BYTE_W +: BYTE_W];
          trg_nxt    = 1'b1;
          state_nxt  = SEND_ADDR;
        end
      end
      // The strobe cycle counts as cycle 0 of the busy wait, so the
      // abort lands TIMEOUT+1 cycles after the strobe.
      SEND_ADDR: begin
        datain_nxt = addr_q;
        cnt_nxt    = CNT_W'(1);
        state_nxt  = WAIT_ADDR_HI;
      end
      WAIT_ADDR_HI, WAIT_DATA_HI: begin
        if (RS_BUSY) begin
          state_nxt = (state_q == WAIT_ADDR_HI) ? WAIT_ADDR_LO : WAIT_DATA_LO;
        end else if (cnt_q >= CNT_W'(TIMEOUT)) begin
          state_nxt      = DONE;
          err_nxt        = 1'b1;
          ack_nxt[gnt_q] = 1'b1;
        end else begin
          cnt_nxt = cnt_q + 1'b1;
        end
      end
      WAIT_ADDR_LO: begin
        if (!RS_BUSY) begin
          datain_nxt = data_q;
          trg_nxt    = 1'b1;
          state_nxt  = SEND_DATA;
        end
      end
      SEND_DATA: begin
        cnt_nxt   = CNT_W'(1);
        state_nxt = WAIT_DATA_HI;
      end
      WAIT_DATA_LO: begin
        if (!RS_BUSY) begin
          ack_nxt[gnt_q] = 1'b1;
          state_nxt      = DONE;
        end
      end
      DONE: begin
        last_nxt  = gnt_q;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK_50MHZ or posedge RST) begin
    if (RST) begin
      state_q      <= IDLE;
      last_q       <= IDX_W'(N_REQ - 1);
      gnt_q        <= '0;
      cnt_q        <= '0;
      addr_q       <= '0;
      data_q       <= '0;
      RS_DATAIN    <= '0;
      RS_TRG_WRITE <= 1'b0;
      ack          <= '0;
      tx_err       <= 1'b0;
      busy         <= 1'b0;
    end else begin
      state_q      <= state_nxt;
      last_q       <= last_nxt;
      gnt_q        <= gnt_nxt;
      cnt_q        <= cnt_nxt;
      addr_q       <= addr_nxt;
      data_q       <= data_nxt;
      RS_DATAIN    <= datain_nxt;
      RS_TRG_WRITE <= trg_nxt;
      ack          <= ack_nxt;
      tx_err       <= err_nxt;
      busy         <= (state_nxt != IDLE);
    end
  end

endmodule

// File: tb/tb_manager_tx_arbiter.sv
module tb_manager_tx_arbiter;

  localparam int N   = 4;
  localparam int TMO = 20;

  logic           CLK_50MHZ = 1'b0;
  logic           RST = 1'b1;
  logic [N-1:0]   req = '0;
  logic [8*N-1:0] addr_tx = '0;
  logic [8*N-1:0] data_tx = '0;
  logic [N-1:0]   ack;
  logic           RS_BUSY;
  logic [7:0]     RS_DATAIN;
  logic           RS_TRG_WRITE;
  logic           tx_err;
  logic           busy;

  manager_tx_arbiter #(.N_REQ(N), .TIMEOUT(TMO)) dut (
    .CLK_50MHZ   (CLK_50MHZ),
    .RST         (RST),
    .req         (req),
    .addr_tx     (addr_tx),
    .data_tx     (data_tx),
    .ack         (ack),
    .RS_BUSY     (RS_BUSY),
    .RS_DATAIN   (RS_DATAIN),
    .RS_TRG_WRITE(RS_TRG_WRITE),
    .tx_err      (tx_err),
    .busy        (busy)
  );

  always #10 CLK_50MHZ = ~CLK_50MHZ;

  // UART model: a strobe starts busy_len cycles of RS_BUSY.
  bit       uart_en   = 1'b1;
  bit       busy_hold = 1'b0;
  int       busy_len  = 10;
  int       bcnt;
  always @(posedge CLK_50MHZ or posedge RST) begin
    if (RST) bcnt <= 0;
    else if (uart_en && RS_TRG_WRITE) bcnt <= busy_len;
    else if (bcnt != 0) bcnt <= bcnt - 1;
  end
  assign RS_BUSY = (bcnt != 0) | busy_hold;

  // Bus monitor
  logic [7:0]   tx_log[$];
  logic [N-1:0] ack_log[$];
  int           err_cnt;
  always @(negedge CLK_50MHZ) begin
    if (RS_TRG_WRITE) tx_log.push_back(RS_DATAIN);
    if (|ack) ack_log.push_back(ack);
    if (tx_err) err_cnt++;
  end

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] tx_at(input int i);
    return (tx_log.size() > i) ? {24'h0, tx_log[i]} : 32'hDEAD;
  endfunction

  function automatic logic [31:0] ack_at(input int i);
    return (ack_log.size() > i) ? 32'(ack_log[i]) : 32'hDEAD;
  endfunction

  task automatic clear_logs();
    tx_log.delete();
    ack_log.delete();
    err_cnt = 0;
  endtask

  task automatic set_bytes(input int idx, input logic [7:0] a, input logic [7:0] d);
    addr_tx[idx*8 +: 8] = a;
    data_tx[idx*8 +: 8] = d;
  endtask

  task automatic wait_ack(input int idx, input int bound, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < bound; c++) begin
      @(negedge CLK_50MHZ);
      if (ack[idx]) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  typedef struct {
    int         idx;
    logic [7:0] a;
    logic [7:0] d;
    int         blen;
    logic [7:0] exp_b0;
    logic [7:0] exp_b1;
    logic [3:0] exp_ack;
  } vec_t;

  vec_t vecs[4];

  initial begin
    bit ok;
    int strobe_cyc, err_cyc, ack_cyc, nstrobe, c;

    vecs[0] = '{0, 8'h12, 8'h34, 10, 8'h12, 8'h34, 4'b0001};
    vecs[1] = '{1, 8'h00, 8'hFF,  1, 8'h00, 8'hFF, 4'b0010};
    vecs[2] = '{2, 8'hA5, 8'h5A,  3, 8'hA5, 8'h5A, 4'b0100};
    vecs[3] = '{3, 8'h80, 8'h01,  2, 8'h80, 8'h01, 4'b1000};

    // Reset state
    repeat (3) @(negedge CLK_50MHZ);
    check("rst_datain", 32'(RS_DATAIN), 32'h0);
    check("rst_trg",    32'(RS_TRG_WRITE), 32'h0);
    check("rst_ack",    32'(ack), 32'h0);
    check("rst_txerr",  32'(tx_err), 32'h0);
    check("rst_busy",   32'(busy), 32'h0);
    RST = 1'b0;
    repeat (2) @(negedge CLK_50MHZ);

    // Single-requester frames
    foreach (vecs[i]) begin
      clear_logs();
      busy_len = vecs[i].blen;
      set_bytes(vecs[i].idx, vecs[i].a, vecs[i].d);
      req[vecs[i].idx] = 1'b1;
      wait_ack(vecs[i].idx, 200, ok);
      req[vecs[i].idx] = 1'b0;
      check($sformatf("v%0d_ack_seen", i), 32'(ok), 32'h1);
      repeat (4) @(negedge CLK_50MHZ);
      check($sformatf("v%0d_nstrobe", i), tx_log.size(), 2);
      check($sformatf("v%0d_addr", i), tx_at(0), 32'(vecs[i].exp_b0));
      check($sformatf("v%0d_data", i), tx_at(1), 32'(vecs[i].exp_b1));
      check($sformatf("v%0d_nack", i), ack_log.size(), 1);
      check($sformatf("v%0d_ackval", i), ack_at(0), 32'(vecs[i].exp_ack));
      check($sformatf("v%0d_noerr", i), err_cnt, 0);
      check($sformatf("v%0d_idle", i), 32'(busy), 32'h0);
    end

    // Fairness: all four held for 8 frames, last grant was 3
    clear_logs();
    busy_len = 2;
    for (int i = 0; i < N; i++) set_bytes(i, 8'(8'h10 + i), 8'(8'h20 + i));
    req = 4'b1111;
    c = 0;
    for (int k = 0; k < 2000 && c < 8; k++) begin
      @(negedge CLK_50MHZ);
      if (|ack) c++;
      if (c == 8) req = 4'b0000;
    end
    req = 4'b0000;
    repeat (4) @(negedge CLK_50MHZ);
    check("fair_nack", ack_log.size(), 8);
    for (int k = 0; k < 8; k++) begin
      check($sformatf("fair_ack%0d", k), ack_at(k), 32'(4'b0001 << (k % 4)));
      check($sformatf("fair_addr%0d", k), tx_at(2*k), 32'(8'h10 + (k % 4)));
    end

    // Timeout: UART never raises busy
    clear_logs();
    uart_en = 1'b0;
    set_bytes(1, 8'h61, 8'h62);
    req[1] = 1'b1;
    strobe_cyc = -1; err_cyc = -1; ack_cyc = -1; nstrobe = 0;
    for (int k = 0; k < 200; k++) begin
      @(negedge CLK_50MHZ);
      if (RS_TRG_WRITE) begin
        nstrobe++;
        if (strobe_cyc < 0) strobe_cyc = k;
      end
      if (tx_err && err_cyc < 0) err_cyc = k;
      if (ack[1] && ack_cyc < 0) begin
        ack_cyc = k;
        req[1] = 1'b0;
      end
      if (ack_cyc >= 0 && k > ack_cyc + 10) break;
    end
    req[1] = 1'b0;
    check("tmo_err_delay", err_cyc - strobe_cyc, TMO + 1);
    check("tmo_ack_with_err", ack_cyc, err_cyc);
    check("tmo_one_strobe", nstrobe, 1);
    check("tmo_err_pulses", err_cnt, 1);
    check("tmo_idle", 32'(busy), 32'h0);
    uart_en = 1'b1;

    // Data change after grant is ignored
    clear_logs();
    busy_len = 4;
    set_bytes(2, 8'h77, 8'h55);
    req[2] = 1'b1;
    for (int k = 0; k < 20 && !busy; k++) @(negedge CLK_50MHZ);
    data_tx[2*8 +: 8] = 8'hAA;
    addr_tx[2*8 +: 8] = 8'h00;
    wait_ack(2, 200, ok);
    req[2] = 1'b0;
    repeat (4) @(negedge CLK_50MHZ);
    check("chg_ack_seen", 32'(ok), 32'h1);
    check("chg_addr", tx_at(0), 32'h77);
    check("chg_data", tx_at(1), 32'h55);

    // Reset during WAIT_DATA_LO
    busy_len = 10;
    set_bytes(2, 8'h3C, 8'hC3);
    clear_logs();
    req[2] = 1'b1;
    nstrobe = 0;
    for (int k = 0; k < 200 && nstrobe < 2; k++) begin
      @(negedge CLK_50MHZ);
      if (RS_TRG_WRITE) nstrobe++;
    end
    check("rmid_reached", nstrobe, 2);
    repeat (3) @(negedge CLK_50MHZ);
    RST = 1'b1;
    #1;
    check("rmid_out", {RS_DATAIN, 3'b0, RS_TRG_WRITE, ack, 3'b0, tx_err, 3'b0, busy}, 32'h0);
    check("rmid_noack", ack_log.size(), 0);
    repeat (2) @(negedge CLK_50MHZ);
    clear_logs();
    RST = 1'b0;
    wait_ack(2, 200, ok);
    req[2] = 1'b0;
    repeat (4) @(negedge CLK_50MHZ);
    check("rmid_resend_ack", ack_at(0), 32'h4);
    check("rmid_resend_addr", tx_at(0), 32'h3C);
    check("rmid_resend_data", tx_at(1), 32'hC3);

    // RS_BUSY high at idle blocks the grant
    clear_logs();
    busy_hold = 1'b1;
    busy_len = 3;
    set_bytes(0, 8'h9A, 8'hBC);
    req[0] = 1'b1;
    repeat (10) @(negedge CLK_50MHZ);
    check("bidle_nostrobe", tx_log.size(), 0);
    check("bidle_notbusy", 32'(busy), 32'h0);
    busy_hold = 1'b0;
    wait_ack(0, 200, ok);
    req[0] = 1'b0;
    repeat (4) @(negedge CLK_50MHZ);
    check("bidle_ack_seen", 32'(ok), 32'h1);
    check("bidle_addr", tx_at(0), 32'h9A);
    check("bidle_data", tx_at(1), 32'hBC);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
